// File: rtl/wash_cycle_timer.sv
// Timing and supervision companion for automatic_washing_machine.
// Generates the wash/spin timeouts from per-program durations, runs the
// fill/drain watchdog and reports the remaining time of the active phase.
module wash_cycle_timer #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned WASH_NORMAL = 600,
    parameter int unsigned WASH_QUICK  = 300,
    parameter int unsigned WASH_HEAVY  = 1200,
    parameter int unsigned SPIN_NORMAL = 200,
    parameter int unsigned SPIN_QUICK  = 100,
    parameter int unsigned SPIN_HEAVY  = 300,
    parameter int unsigned FILL_LIMIT  = 500,
    parameter int unsigned DRAIN_LIMIT = 400
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       state_in,
    input  logic [1:0]       program_sel,
    input  logic             pause,
    output logic             cycle_time_out,
    output logic             spin_time_out,
    output logic             fault,
    output logic             busy,
    output logic [CNT_W-1:0] remaining
);

    // Machine state codes as seen on state_in
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_DET   = 3'd2;
    localparam logic [2:0] ST_WASH  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_SPIN  = 3'd5;

    // Per-phase timer states
    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_RUN  = 2'd1;
    localparam logic [1:0] T_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]       prev_state;
    logic [1:0]       prog;

    logic [1:0]       wash_st,  wash_st_nxt;
    logic [CNT_W-1:0] wash_cnt, wash_cnt_nxt;
    logic [1:0]       spin_st,  spin_st_nxt;
    logic [CNT_W-1:0] spin_cnt, spin_cnt_nxt;

    logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt;
    logic             fault_reg, fault_nxt;

    logic [CNT_W-1:0] wash_dur, spin_dur;
    logic [CNT_W-1:0] wash_load, spin_load;
    logic             phase_entry;

    assign phase_entry = (state_in != prev_state);

    // Duration lookup from the latched program; the reserved code runs as normal
    always_comb begin
        wash_dur = CNT_W'(WASH_NORMAL);
        spin_dur = CNT_W'(SPIN_NORMAL);
        case (prog)
            2'd1: begin
                wash_dur = CNT_W'(WASH_QUICK);
                spin_dur = CNT_W'(SPIN_QUICK);
            end
            2'd2: begin
                wash_dur = CNT_W'(WASH_HEAVY);
                spin_dur = CNT_W'(SPIN_HEAVY);
            end
            default: begin
                wash_dur = CNT_W'(WASH_NORMAL);
                spin_dur = CNT_W'(SPIN_NORMAL);
            end
        endcase
        // A zero duration still needs one edge to reach DONE
        wash_load = (wash_dur == '0) ? CNT_ONE : wash_dur;
        spin_load = (spin_dur == '0) ? CNT_ONE : spin_dur;
    end

    // Wash phase timer next-state: load on entry, count down unless paused
    always_comb begin
        wash_st_nxt  = wash_st;
        wash_cnt_nxt = wash_cnt;
        if (state_in != ST_WASH) begin
            wash_st_nxt  = T_IDLE;
            wash_cnt_nxt = '0;
        end else if (prev_state != ST_WASH) begin
            wash_st_nxt  = T_RUN;
            wash_cnt_nxt = wash_load;
        end else if (wash_st == T_RUN && !pause) begin
            if (wash_cnt <= CNT_ONE) begin
                wash_st_nxt  = T_DONE;
                wash_cnt_nxt = '0;
            end else begin
                wash_cnt_nxt = wash_cnt - CNT_ONE;
            end
        end
    end

    // Spin phase timer next-state: same behaviour as the wash timer
    always_comb begin
        spin_st_nxt  = spin_st;
        spin_cnt_nxt = spin_cnt;
        if (state_in != ST_SPIN) begin
            spin_st_nxt  = T_IDLE;
            spin_cnt_nxt = '0;
        end else if (prev_state != ST_SPIN) begin
            spin_st_nxt  = T_RUN;
            spin_cnt_nxt = spin_load;
        end else if (spin_st == T_RUN && !pause) begin
            if (spin_cnt <= CNT_ONE) begin
                spin_st_nxt  = T_DONE;
                spin_cnt_nxt = '0;
            end else begin
                spin_cnt_nxt = spin_cnt - CNT_ONE;
            end
        end
    end

    // Watchdog: restart on any phase change, saturating count in FILL/DRAIN
    always_comb begin
        wd_cnt_nxt = wd_cnt;
        fault_nxt  = fault_reg;
        if (phase_entry) begin
            wd_cnt_nxt = '0;
        end else if ((state_in == ST_FILL || state_in == ST_DRAIN) && !pause) begin
            if (wd_cnt != CNT_MAX) begin
                wd_cnt_nxt = wd_cnt + CNT_ONE;
            end
        end
        if (!phase_entry) begin
            if (state_in == ST_FILL && wd_cnt_nxt >= CNT_W'(FILL_LIMIT)) begin
                fault_nxt = 1'b1;
            end
            if (state_in == ST_DRAIN && wd_cnt_nxt >= CNT_W'(DRAIN_LIMIT)) begin
                fault_nxt = 1'b1;
            end
        end
    end

    // State registers; reset aborts any phase in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_state <= ST_IDLE;
            prog       <= 2'd0;
            wash_st    <= T_IDLE;
            wash_cnt   <= '0;
            spin_st    <= T_IDLE;
            spin_cnt   <= '0;
            wd_cnt     <= '0;
            fault_reg  <= 1'b0;
        end else begin
            prev_state <= state_in;
            if (prev_state == ST_IDLE && state_in == ST_FILL) begin
                prog <= program_sel;
            end
            wash_st    <= wash_st_nxt;
            wash_cnt   <= wash_cnt_nxt;
            spin_st    <= spin_st_nxt;
            spin_cnt   <= spin_cnt_nxt;
            wd_cnt     <= wd_cnt_nxt;
            fault_reg  <= fault_nxt;
        end
    end

    // Outputs follow state_in directly so timeouts drop the cycle the phase ends
    always_comb begin
        busy           = (state_in != ST_IDLE);
        fault          = fault_reg;
        cycle_time_out = (wash_st == T_DONE) && (state_in == ST_WASH) && !fault_reg;
        spin_time_out  = (spin_st == T_DONE) && (state_in == ST_SPIN) && !fault_reg;
        remaining      = '0;
        if (wash_st == T_RUN && state_in == ST_WASH) begin
            remaining = wash_cnt;
        end else if (spin_st == T_RUN && state_in == ST_SPIN) begin
            remaining = spin_cnt;
        end
    end

endmodule

// File: tb/tb_wash_cycle_timer.sv
// Self-checking bench for wash_cycle_timer: a short vector table followed by
// hand-written multi-cycle sequences using the default durations.
module tb_wash_cycle_timer;

    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_DET   = 3'd2;
    localparam logic [2:0] ST_WASH  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_SPIN  = 3'd5;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       state_in;
    logic [1:0]       program_sel;
    logic             pause;
    logic             cycle_time_out;
    logic             spin_time_out;
    logic             fault;
    logic             busy;
    logic [CNT_W-1:0] remaining;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic       rst;
        logic [2:0] st;
        logic [1:0] prg;
        logic       pse;
        logic       e_cto;
        logic       e_sto;
        logic       e_fault;
        logic       e_busy;
        int         e_rem;
    } vec_t;

    vec_t vecs[12];

    wash_cycle_timer dut (
        .clk            (clk),
        .reset          (reset),
        .state_in       (state_in),
        .program_sel    (program_sel),
        .pause          (pause),
        .cycle_time_out (cycle_time_out),
        .spin_time_out  (spin_time_out),
        .fault          (fault),
        .busy           (busy),
        .remaining      (remaining)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [2:0] st, input logic [1:0] prg,
                                input logic pse, input logic e_cto, input logic e_sto,
                                input logic e_fault, input logic e_busy, input int e_rem);
        vec_t v;
        v.rst = rst; v.st = st; v.prg = prg; v.pse = pse;
        v.e_cto = e_cto; v.e_sto = e_sto; v.e_fault = e_fault;
        v.e_busy = e_busy; v.e_rem = e_rem;
        return v;
    endfunction

    function automatic logic sig(input int which);
        case (which)
            0:       return cycle_time_out;
            1:       return spin_time_out;
            default: return fault;
        endcase
    endfunction

    // Ticks until the selected output rises; n is the edge count since entry, -1 if never
    task automatic measure(input int which, input int start, input int budget, output int n);
        n = start;
        while (!sig(which) && n < budget) begin
            tick();
            n++;
        end
        if (!sig(which)) n = -1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        state_in = ST_IDLE;
        pause    = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic go(input logic [2:0] st);
        state_in = st;
        tick();
    endtask

    initial begin
        int n;
        logic seen;

        reset       = 1'b1;
        state_in    = ST_IDLE;
        program_sel = 2'd0;
        pause       = 1'b0;

        //            rst  st        prg   pse  cto  sto  flt  busy rem
        vecs[0]  = mk(1'b1, ST_IDLE,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        vecs[1]  = mk(1'b0, ST_IDLE,  2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        vecs[2]  = mk(1'b0, ST_FILL,  2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        vecs[3]  = mk(1'b0, ST_DET,   2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        vecs[4]  = mk(1'b0, ST_WASH,  2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 300);
        vecs[5]  = mk(1'b0, ST_WASH,  2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 299);
        vecs[6]  = mk(1'b0, ST_WASH,  2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 299);
        vecs[7]  = mk(1'b0, ST_WASH,  2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 298);
        vecs[8]  = mk(1'b0, 3'd6,     2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        vecs[9]  = mk(1'b0, ST_WASH,  2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 300);
        vecs[10] = mk(1'b0, ST_WASH,  2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 299);
        vecs[11] = mk(1'b0, ST_IDLE,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            reset       = vecs[i].rst;
            state_in    = vecs[i].st;
            program_sel = vecs[i].prg;
            pause       = vecs[i].pse;
            tick();
            check($sformatf("vec%0d_cto", i),   int'(cycle_time_out), int'(vecs[i].e_cto));
            check($sformatf("vec%0d_sto", i),   int'(spin_time_out),  int'(vecs[i].e_sto));
            check($sformatf("vec%0d_fault", i), int'(fault),          int'(vecs[i].e_fault));
            check($sformatf("vec%0d_busy", i),  int'(busy),           int'(vecs[i].e_busy));
            check($sformatf("vec%0d_rem", i),   int'(remaining),      vecs[i].e_rem);
        end

        // Quick wash: timeout 300 edges after entry, drops the cycle WASH is left
        do_reset();
        program_sel = 2'd1;
        go(ST_FILL);
        go(ST_DET);
        go(ST_WASH);
        tick();
        check("quick_rem_first", int'(remaining), 299);
        measure(0, 1, 400, n);
        check("quick_wash_edges", n, 300);
        check("quick_rem_done", int'(remaining), 0);
        state_in = ST_DRAIN;
        #1;
        check("quick_cto_fall", int'(cycle_time_out), 0);
        tick();

        // Normal wash with a 50-cycle pause in the middle
        do_reset();
        program_sel = 2'd0;
        go(ST_FILL);
        go(ST_DET);
        go(ST_WASH);
        for (int i = 0; i < 100; i++) tick();
        check("pause_rem_before", int'(remaining), 500);
        pause = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        check("pause_rem_frozen", int'(remaining), 500);
        check("pause_cto_low", int'(cycle_time_out), 0);
        pause = 1'b0;
        measure(0, 150, 800, n);
        check("pause_wash_edges", n, 650);

        // Heavy program; program_sel changes mid-cycle are ignored
        do_reset();
        program_sel = 2'd2;
        go(ST_FILL);
        program_sel = 2'd1;
        go(ST_DET);
        go(ST_WASH);
        measure(0, 0, 1400, n);
        check("heavy_wash_edges", n, 1200);
        go(ST_DRAIN);
        go(ST_SPIN);
        check("heavy_rem_spin_entry", int'(remaining), 300);
        measure(1, 0, 400, n);
        check("heavy_spin_edges", n, 300);
        state_in = ST_IDLE;
        #1;
        check("heavy_sto_fall", int'(spin_time_out), 0);
        check("heavy_rem_idle", int'(remaining), 0);
        check("heavy_busy_idle", int'(busy), 0);
        tick();

        // Fill watchdog: fault on edge 500, sticky, masks wash timeout
        do_reset();
        program_sel = 2'd0;
        go(ST_FILL);
        measure(2, 0, 600, n);
        check("fill_fault_edges", n, 500);
        go(ST_WASH);
        seen = 1'b0;
        for (int i = 0; i < 700; i++) begin
            tick();
            seen = seen | cycle_time_out;
        end
        check("fault_masks_cto", int'(seen), 0);
        check("fault_sticky", int'(fault), 1);
        do_reset();
        check("fault_cleared", int'(fault), 0);

        // Drain watchdog: fault on edge 400
        go(ST_FILL);
        go(ST_DRAIN);
        check("drain_no_fault_entry", int'(fault), 0);
        measure(2, 0, 500, n);
        check("drain_fault_edges", n, 400);

        // Early exit from WASH then return: full reload, no early timeout
        do_reset();
        program_sel = 2'd1;
        go(ST_FILL);
        go(ST_DET);
        go(ST_WASH);
        for (int i = 0; i < 100; i++) tick();
        check("early_rem", int'(remaining), 200);
        state_in = ST_DRAIN;
        #1;
        check("early_exit_cto", int'(cycle_time_out), 0);
        check("early_exit_rem", int'(remaining), 0);
        tick();
        program_sel = 2'd2;
        go(ST_WASH);
        check("reentry_rem", int'(remaining), 300);
        measure(0, 0, 400, n);
        check("reentry_wash_edges", n, 300);

        // Reset while spin timeout is up, then reserved program runs as normal
        go(ST_DRAIN);
        go(ST_SPIN);
        measure(1, 0, 200, n);
        check("quick_spin_edges", n, 100);
        reset = 1'b1;
        tick();
        check("rst_sto", int'(spin_time_out), 0);
        check("rst_cto", int'(cycle_time_out), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_rem", int'(remaining), 0);
        state_in    = ST_IDLE;
        program_sel = 2'd3;
        tick();
        reset = 1'b0;
        go(ST_FILL);
        go(ST_DET);
        go(ST_WASH);
        measure(0, 0, 800, n);
        check("rsvd_wash_edges", n, 600);
        go(ST_DRAIN);
        go(ST_SPIN);
        measure(1, 0, 300, n);
        check("rsvd_spin_edges", n, 200);
        go(ST_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wash_cycle_timer.md
Name: wash_cycle_timer

Overview:
- Timing and supervision controller that sits beside automatic_washing_machine.
- Watches the machine's 3-bit state output and generates its cycle_time_out and spin_time_out inputs from programmable durations.
- Durations are selected by a wash program latched at cycle start.
- Also runs watchdogs on the fill and drain phases, raises a sticky fault on overrun, and exposes a remaining-time count for display.

Parameters:
- CNT_W, 16, width of all duration counters and of remaining
- WASH_NORMAL, 600, wash duration in clk cycles, program 0
- WASH_QUICK, 300, wash duration, program 1
- WASH_HEAVY, 1200, wash duration, program 2
- SPIN_NORMAL, 200, spin duration, program 0
- SPIN_QUICK, 100, spin duration, program 1
- SPIN_HEAVY, 300, spin duration, program 2
- FILL_LIMIT, 500, max cycles allowed in FILL before fault
- DRAIN_LIMIT, 400, max cycles allowed in DRAIN before fault
- ST_IDLE/ST_FILL/ST_DET/ST_WASH/ST_DRAIN/ST_SPIN, 3'd0/1/2/3/4/5, machine state codes on state_in

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- state_in  input  3  machine state (the machine's out bus)
- program_sel  input  2  0=normal, 1=quick, 2=heavy, 3=reserved (treated as normal)
- pause  input  1  freezes all duration and watchdog counters while high
- cycle_time_out  output  1  to machine; wash phase complete
- spin_time_out  output  1  to machine; spin phase complete
- fault  output  1  sticky watchdog overrun flag
- busy  output  1  high when state_in != ST_IDLE (combinational)
- remaining  output  CNT_W  cycles left in current WASH/SPIN phase, else 0

Behaviour:
- Reset values: all outputs 0; counters 0; latched program = 0; prev_state = ST_IDLE.
  - Reset asserted mid-phase aborts immediately: timeouts and fault drop on the next edge.
- prev_state register holds state_in from the previous edge. Phase entry = state_in != prev_state.
- Program latch:
  - Latched on the edge where prev_state==ST_IDLE and state_in==ST_FILL.
  - Held until the next such transition; program_sel changes mid-cycle are ignored.
- Internal FSM, one per timed phase (WASH, SPIN): T_IDLE -> T_RUN -> T_DONE.
  - Entry edge (state_in==ST_WASH, prev_state!=ST_WASH): load counter with D = latched wash duration; go to T_RUN. D=0 is treated as 1.
  - T_RUN: decrement on each edge where pause==0. The edge where counter goes 1->0 enters T_DONE.
  - Net effect: cycle_time_out rises exactly D edges after the entry edge, plus one edge per paused cycle.
  - T_DONE: timeout_reg=1.
  - cycle_time_out = timeout_reg AND (state_in==ST_WASH) AND NOT fault. It falls in the same cycle the machine leaves WASH, with no stale pulse.
  - Any edge with state_in != phase state: FSM returns to T_IDLE and the counter clears. An early exit leaves no residual timeout.
  - SPIN is identical, using the spin duration and spin_time_out.
- Re-entry into WASH later (new cycle) reloads D; no carry-over.
- remaining = active phase counter while in T_RUN; 0 in T_DONE or when no timed phase is active.
- Watchdogs:
  - One CNT_W up-counter, reset on every phase entry.
  - Increments while state_in is ST_FILL or ST_DRAIN and pause==0.
  - Reaching FILL_LIMIT in FILL, or DRAIN_LIMIT in DRAIN, sets fault=1 on that edge.
  - fault is sticky until reset and forces both timeouts low.
  - The watchdog counter saturates; no wrap.
- ST_DET and undefined codes (6, 7): no timers run; timeouts 0. Undefined codes clear phase FSMs like any non-phase state.
- Simultaneous events:
  - Pause on the entry edge: the load still happens; the decrement starts on the first unpaused edge.
  - Reset wins over everything.
- All counters are CNT_W wide. Durations exceeding 2^CNT_W-1 are a parameter error, not handled.

Test Plan:
- Reset, then program_sel=1, state_in IDLE->FILL->DET->WASH -> cycle_time_out rises exactly 300 edges after WASH entry; remaining reads 299 on the first edge after entry.
- In WASH (program 0), pause high for 50 cycles mid-phase -> cycle_time_out at 650 edges; remaining frozen during pause.
- state_in WASH->DRAIN->SPIN, program 2 latched -> spin_time_out at 300 edges. Move state_in to IDLE -> spin_time_out falls same cycle, remaining=0.
- Hold state_in=FILL for 500 cycles -> fault=1 on edge 500. Then force WASH for 600+ cycles -> cycle_time_out stays 0; fault held until reset.
- Leave WASH after 100 cycles, return to WASH -> counter reloads full D; no early timeout. Change program_sel mid-cycle -> durations unchanged.
- Assert reset during SPIN T_DONE -> all outputs 0 next edge; program_sel=3 next cycle -> normal durations (600/200).
